// File: rtl/fp_pkg.sv
// Shared definitions for the streaming floating-point blocks: FSM state
// encoding, exception-flag bit positions and format-derived constants.
package fp_pkg;

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
        NORM_1, NORM_2, ROUND, PACK, PUT_Z
    } state_t;

    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 1, exponent all ones, fraction MSB only.
    function automatic logic [127:0] fp_canon_nan(input int ew, input int mw);
        logic [127:0] v;
        v = '0;
        v[ew + mw] = 1'b1;
        for (int i = 0; i < ew; i++) v[mw + i] = 1'b1;
        v[mw - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier for an IEEE-754 word of generic width.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic [EW+MW:0] x,
    output logic           is_nan,
    output logic           is_inf,
    output logic           is_zero,
    output logic           is_denorm
);

    logic exp_ones;
    logic exp_zero;
    logic frac_zero;

    assign exp_ones  = &x[EW+MW-1:MW];
    assign exp_zero  = ~|x[EW+MW-1:MW];
    assign frac_zero = ~|x[MW-1:0];

    assign is_nan    = exp_ones & ~frac_zero;
    assign is_inf    = exp_ones & frac_zero;
    assign is_zero   = exp_zero & frac_zero;
    assign is_denorm = exp_zero & ~frac_zero;

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor with generic exponent/fraction widths,
// round-to-nearest-even and {invalid, overflow, inexact} flags.
module fp_addsub
    import fp_pkg::*;
#(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [EW+MW:0] input_a,
    input  logic          input_a_stb,
    output logic          input_a_ack,
    input  logic [EW+MW:0] input_b,
    input  logic          input_b_op,
    input  logic          input_b_stb,
    output logic          input_b_ack,
    output logic [EW+MW:0] output_z,
    output logic [2:0]    output_z_flags,
    output logic          output_z_stb,
    input  logic          output_z_ack,
    output logic [3:0]    dbg_state
);

    localparam int W = 1 + EW + MW;
    localparam int BIAS = fp_bias(EW);
    localparam logic [127:0] NAN_FULL = fp_canon_nan(EW, MW);
    localparam logic [W-1:0] NAN_Z = NAN_FULL[W-1:0];
    localparam logic signed [EW+1:0] BIAS_E  = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] MIN_E   = (EW+2)'(1 - BIAS);
    localparam logic signed [EW+1:0] ONE_E   = (EW+2)'(1);
    localparam logic signed [EW+1:0] SHORT_D = (EW+2)'(MW + 3);
    localparam logic [2:0] F_INVALID  = 3'(1 << FLAG_INVALID);
    localparam logic [2:0] F_OVERFLOW = 3'(1 << FLAG_OVERFLOW);
    localparam logic [2:0] F_INEXACT  = 3'(1 << FLAG_INEXACT);

    state_t state;
    logic [W-1:0] a, b;
    logic s_a, s_b, z_s, inexact;
    logic signed [EW+1:0] e_a, e_b, z_e;
    logic [MW+3:0] m_a, m_b, z_m;
    logic [MW+4:0] sum;
    logic a_nan, a_inf, a_zero, a_den;
    logic b_nan, b_inf, b_zero, b_den;
    logic signed [EW+1:0] diff_ab, diff_ba;
    logic [MW+1:0] rnd_sum;
    logic round_up;
    logic [EW-1:0] exp_biased;

    fp_classify #(.EW(EW), .MW(MW)) u_cls_a (
        .x(a), .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero), .is_denorm(a_den)
    );
    fp_classify #(.EW(EW), .MW(MW)) u_cls_b (
        .x(b), .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero), .is_denorm(b_den)
    );

    assign diff_ab    = e_a - e_b;
    assign diff_ba    = e_b - e_a;
    assign round_up   = z_m[2] & (z_m[1] | z_m[0] | z_m[3]);
    assign rnd_sum    = {1'b0, z_m[MW+3:3]} + {{(MW+1){1'b0}}, 1'b1};
    assign exp_biased = EW'(z_e + BIAS_E);
    assign dbg_state  = state;

    // Streams move a word on any edge where stb and ack are both high; acks and
    // output_z_stb are registered, so each rises one cycle after its state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= GET_A;
            input_a_ack <= 1'b0;
            input_b_ack <= 1'b0;
            output_z_stb <= 1'b0;
            output_z <= '0;
            output_z_flags <= '0;
            a <= '0; b <= '0;
            s_a <= 1'b0; s_b <= 1'b0; z_s <= 1'b0; inexact <= 1'b0;
            e_a <= '0; e_b <= '0; z_e <= '0;
            m_a <= '0; m_b <= '0; z_m <= '0; sum <= '0;
        end else begin
            case (state)
                GET_A: begin
                    if (input_a_ack && input_a_stb) begin
                        a <= input_a;
                        input_a_ack <= 1'b0;
                        state <= GET_B;
                    end else input_a_ack <= 1'b1;
                end
                GET_B: begin
                    if (input_b_ack && input_b_stb) begin
                        b <= {input_b[W-1] ^ input_b_op, input_b[W-2:0]};
                        input_b_ack <= 1'b0;
                        state <= UNPACK;
                    end else input_b_ack <= 1'b1;
                end
                UNPACK: begin
                    s_a <= a[W-1];
                    s_b <= b[W-1];
                    e_a <= $signed({2'b00, a[W-2:MW]}) - BIAS_E;
                    e_b <= $signed({2'b00, b[W-2:MW]}) - BIAS_E;
                    m_a <= {1'b0, a[MW-1:0], 3'b000};
                    m_b <= {1'b0, b[MW-1:0], 3'b000};
                    state <= SPECIAL;
                end
                SPECIAL: begin
                    state <= PUT_Z;
                    output_z_flags <= '0;
                    if (a_nan || b_nan || (a_inf && b_inf && (s_a != s_b))) begin
                        output_z <= NAN_Z;
                        output_z_flags <= F_INVALID;
                    end else if (a_inf) output_z <= a;
                    else if (b_inf) output_z <= b;
                    else if (a_zero && b_zero) output_z <= {s_a & s_b, {(W-1){1'b0}}};
                    else if (a_zero) output_z <= b;
                    else if (b_zero) output_z <= a;
                    else begin
                        state <= ALIGN;
                        if (a_den) e_a <= MIN_E; else m_a[MW+3] <= 1'b1;
                        if (b_den) e_b <= MIN_E; else m_b[MW+3] <= 1'b1;
                    end
                end
                // Leaves on the cycle of the last shift, so a difference of d costs d cycles.
                ALIGN: begin
                    if (diff_ab == '0) state <= ADD_0;
                    else if (!diff_ab[EW+1]) begin
                        if (diff_ab > SHORT_D) begin
                            m_b <= {{(MW+3){1'b0}}, |m_b};
                            e_b <= e_a;
                            state <= ADD_0;
                        end else begin
                            m_b <= {1'b0, m_b[MW+3:2], m_b[1] | m_b[0]};
                            e_b <= e_b + ONE_E;
                            if (diff_ab == ONE_E) state <= ADD_0;
                        end
                    end else begin
                        if (diff_ba > SHORT_D) begin
                            m_a <= {{(MW+3){1'b0}}, |m_a};
                            e_a <= e_b;
                            state <= ADD_0;
                        end else begin
                            m_a <= {1'b0, m_a[MW+3:2], m_a[1] | m_a[0]};
                            e_a <= e_a + ONE_E;
                            if (diff_ba == ONE_E) state <= ADD_0;
                        end
                    end
                end
                ADD_0: begin
                    z_e <= e_a;
                    state <= ADD_1;
                    if (s_a == s_b) begin
                        sum <= {1'b0, m_a} + {1'b0, m_b};
                        z_s <= s_a;
                    end else if (m_a == m_b) begin
                        // Exact cancellation: +0 parked at the minimum exponent.
                        sum <= '0;
                        z_s <= 1'b0;
                        z_e <= MIN_E;
                    end else if (m_a > m_b) begin
                        sum <= {1'b0, m_a} - {1'b0, m_b};
                        z_s <= s_a;
                    end else begin
                        sum <= {1'b0, m_b} - {1'b0, m_a};
                        z_s <= s_b;
                    end
                end
                ADD_1: begin
                    if (sum[MW+4]) begin
                        z_m <= {sum[MW+4:2], sum[1] | sum[0]};
                        z_e <= z_e + ONE_E;
                    end else z_m <= sum[MW+3:0];
                    state <= NORM_1;
                end
                NORM_1: begin
                    if (!z_m[MW+3] && (z_e > MIN_E)) begin
                        z_m <= {z_m[MW+2:0], 1'b0};
                        z_e <= z_e - ONE_E;
                    end else state <= NORM_2;
                end
                NORM_2: begin
                    if (z_e < MIN_E) begin
                        z_m <= {1'b0, z_m[MW+3:2], z_m[1] | z_m[0]};
                        z_e <= z_e + ONE_E;
                    end else state <= ROUND;
                end
                ROUND: begin
                    inexact <= z_m[2] | z_m[1] | z_m[0];
                    if (round_up) begin
                        if (rnd_sum[MW+1]) begin
                            z_m[MW+3:3] <= rnd_sum[MW+1:1];
                            z_e <= z_e + ONE_E;
                        end else z_m[MW+3:3] <= rnd_sum[MW:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    if (z_e > BIAS_E) begin
                        output_z <= {z_s, {EW{1'b1}}, {MW{1'b0}}};
                        output_z_flags <= F_OVERFLOW | F_INEXACT;
                    end else begin
                        output_z <= {z_s, z_m[MW+3] ? exp_biased : {EW{1'b0}}, z_m[MW+2:3]};
                        output_z_flags <= inexact ? F_INEXACT : 3'b000;
                    end
                    state <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                        state <= GET_A;
                    end else output_z_stb <= 1'b1;
                end
                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub.sv
// Directed bench for fp_addsub: single-precision and half-precision instances
// sharing one clock and reset, with a queue of expected {flags, z} results.
module tb_fp_addsub;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] a_in, b_in, z;
    logic a_stb, a_ack, b_op, b_stb, b_ack, z_stb, z_ack;
    logic [2:0] z_flags;
    logic [3:0] dbg;

    logic [15:0] ha_in, hb_in, hz;
    logic ha_stb, ha_ack, hb_op, hb_stb, hb_ack, hz_stb, hz_ack;
    logic [2:0] hz_flags;
    logic [3:0] hdbg;

    logic [34:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int last_align;

    fp_addsub dut (
        .clk(clk), .rst(rst),
        .input_a(a_in), .input_a_stb(a_stb), .input_a_ack(a_ack),
        .input_b(b_in), .input_b_op(b_op), .input_b_stb(b_stb), .input_b_ack(b_ack),
        .output_z(z), .output_z_flags(z_flags), .output_z_stb(z_stb), .output_z_ack(z_ack),
        .dbg_state(dbg)
    );

    fp_addsub #(.EW(5), .MW(10)) dut_h (
        .clk(clk), .rst(rst),
        .input_a(ha_in), .input_a_stb(ha_stb), .input_a_ack(ha_ack),
        .input_b(hb_in), .input_b_op(hb_op), .input_b_stb(hb_stb), .input_b_ack(hb_ack),
        .output_z(hz), .output_z_flags(hz_flags), .output_z_stb(hz_stb), .output_z_ack(hz_ack),
        .dbg_state(hdbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic op, input logic [31:0] ez, input logic [2:0] ef,
                          input int lat, input int hold);
        logic [34:0] e;
        logic [31:0] held;
        bit stable;
        int n;
        exp_q.push_back({ef, ez});
        @(negedge clk); a_in = av; a_stb = 1'b1;
        n = 0;
        while (!a_ack && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_a_hs"}, 64'(n < 50), 64'(1));
        @(posedge clk); #1 a_stb = 1'b0;
        @(negedge clk); b_in = bv; b_op = op; b_stb = 1'b1;
        n = 0;
        while (!b_ack && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 b_stb = 1'b0;
        last_align = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (dbg == ALIGN) last_align++;
        end while (!z_stb && n < 400);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        e = exp_q.pop_front();
        chk({tag, "_z"}, 64'(z), 64'(e[31:0]));
        chk({tag, "_flags"}, 64'(z_flags), 64'(e[34:32]));
        if (hold > 0) begin
            held = z;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (z !== held || !z_stb || a_ack || dbg != PUT_Z) stable = 1'b0;
            end
            chk({tag, "_hold"}, 64'(stable), 64'(1));
        end
        z_ack = 1'b1;
        @(posedge clk); #1 z_ack = 1'b0;
        chk({tag, "_stb_drop"}, 64'(z_stb), 64'(0));
    endtask

    task automatic run_half(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic op, input logic [15:0] ez, input logic [2:0] ef,
                            input int lat);
        logic [34:0] e;
        int n;
        exp_q.push_back({ef, 16'h0000, ez});
        @(negedge clk); ha_in = av; ha_stb = 1'b1;
        n = 0;
        while (!ha_ack && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 ha_stb = 1'b0;
        @(negedge clk); hb_in = bv; hb_op = op; hb_stb = 1'b1;
        n = 0;
        while (!hb_ack && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 hb_stb = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!hz_stb && n < 400);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        e = exp_q.pop_front();
        chk({tag, "_z"}, 64'({16'h0000, hz}), 64'(e[31:0]));
        chk({tag, "_flags"}, 64'(hz_flags), 64'(e[34:32]));
        hz_ack = 1'b1;
        @(posedge clk); #1 hz_ack = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        a_in = '0; a_stb = 0; b_in = '0; b_op = 0; b_stb = 0; z_ack = 0;
        ha_in = '0; ha_stb = 0; hb_in = '0; hb_op = 0; hb_stb = 0; hz_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(dbg), 64'(GET_A));
        chk("rst_a_ack", 64'(a_ack), 64'(0));
        chk("rst_b_ack", 64'(b_ack), 64'(0));
        chk("rst_z_stb", 64'(z_stb), 64'(0));
        chk("rst_z", 64'(z), 64'(0));
        chk("rst_flags", 64'(z_flags), 64'(0));
        chk("rst_h_stb", 64'(hz_stb), 64'(0));
        @(negedge clk) rst = 1'b0;

        run_op("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 10, 0);
        run_op("sub_1_1",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 10, 0);
        run_op("inf_minf",    32'h7F800000, 32'hFF800000, 1'b0, 32'hFFC00000, 3'b100, 3, 0);
        run_op("inf_sub_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'hFFC00000, 3'b100, 3, 0);
        run_op("nan_in",      32'h7FC00001, 32'h3F800000, 1'b0, 32'hFFC00000, 3'b100, 3, 0);
        run_op("inf_plus_1",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 3, 0);
        run_op("zero_sub_b",  32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000, 3, 0);
        run_op("negz_negz",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 3, 0);
        run_op("ovf",         32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 10, 0);
        run_op("shortcut",    32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001, 10, 0);
        chk("shortcut_align", 64'(last_align), 64'(1));
        run_op("denorm",      32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, 10, 0);
        run_op("add_1_q",     32'h3F800000, 32'h3E800000, 1'b0, 32'h3FA00000, 3'b000, 11, 0);
        chk("add_1_q_align", 64'(last_align), 64'(2));
        run_op("sub_norm",    32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000, 12, 0);
        run_op("sub_neg",     32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 11, 0);
        run_op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 33, 0);
        chk("tie_even_align", 64'(last_align), 64'(24));
        run_op("round_up",    32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001, 33, 0);
        run_op("hold",        32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 10, 20);

        run_half("h_1_1",   16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000, 10);
        run_half("h_ovf",   16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011, 10);
        run_half("h_inf",   16'h7C00, 16'h7C00, 1'b1, 16'hFE00, 3'b100, 3);

        // Asynchronous reset in the middle of a long alignment.
        @(negedge clk); a_in = 32'h3F800000; a_stb = 1'b1;
        n = 0;
        while (!a_ack && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 a_stb = 1'b0;
        @(negedge clk); b_in = 32'h33800000; b_op = 1'b0; b_stb = 1'b1;
        n = 0;
        while (!b_ack && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1 b_stb = 1'b0;
        n = 0;
        while (dbg != ALIGN && n < 20) begin @(posedge clk); #1; n++; end
        chk("mid_reached_align", 64'(dbg), 64'(ALIGN));
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_state", 64'(dbg), 64'(GET_A));
        chk("mid_rst_a_ack", 64'(a_ack), 64'(0));
        chk("mid_rst_b_ack", 64'(b_ack), 64'(0));
        chk("mid_rst_stb", 64'(z_stb), 64'(0));
        @(negedge clk) rst = 1'b0;
        run_op("post_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, 10, 0);

        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
